// File: rtl/bram_port_master.sv
// Initiator for a 32-bit BRAM port: turns a valid/ready request stream into BRAM cycles and
// returns read data through a credit-managed response FIFO. Optional: BRAM_PORT_MASTER_RANGE_CHECK_EN.
module bram_port_master #(
    parameter int unsigned C_MEMSIZE      = 'h8000,
    parameter int unsigned C_READ_LATENCY = 1,
    parameter int unsigned C_PORT_AWIDTH  = 32
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Req_Valid,
    output logic                     Req_Ready,
    input  logic                     Req_Wr,
    input  logic [0:31]              Req_Addr,
    input  logic [0:3]               Req_BE,
    input  logic [0:31]              Req_WData,
    output logic                     Rsp_Valid,
    input  logic                     Rsp_Ready,
    output logic [0:31]              Rsp_RData,
    output logic                     Rsp_Err,
    output logic                     BRAM_Rst,
    output logic                     BRAM_Clk,
    output logic                     BRAM_EN,
    output logic [0:3]               BRAM_WEN,
    output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
    output logic [0:31]              BRAM_Dout,
    input  logic [0:31]              BRAM_Din
);

    localparam int unsigned   D        = C_READ_LATENCY + 2;
    localparam int unsigned   PW       = $clog2(D);
    localparam int unsigned   CW       = $clog2(D) + 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(D - 1);

    if (C_READ_LATENCY == 0 || C_READ_LATENCY > 2 || (C_MEMSIZE & (C_MEMSIZE - 1)) != 0) begin : g_bad_params
        $error("bram_port_master: C_READ_LATENCY must be 1 or 2 and C_MEMSIZE a power of two");
    end

    logic                      fire;
    logic                      issue_en;
    logic                      rd_issue;
    logic                      req_oob;
    logic                      push;
    logic                      push_err;
    logic [0:31]               push_data;
    logic                      pop;
    logic [C_READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [C_READ_LATENCY-1:0] pipe_err_q, pipe_err_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic [CW-1:0]             pipe_cnt;
    logic                      ready_q, ready_d;
    logic [0:31]               data_mem [D];
    logic                      unused_addr_lsbs;

    assign BRAM_Rst  = ~Rst_n;
    assign BRAM_Clk  = Clk;

    // Out-of-range requests still handshake and consume a credit, but never reach the BRAM.
    assign fire      = Req_Valid & ready_q;
    assign issue_en  = fire & ~req_oob;
    assign rd_issue  = fire & ~Req_Wr;
    assign BRAM_EN   = issue_en;
    assign BRAM_WEN  = (issue_en & Req_Wr) ? Req_BE : 4'b0000;
    assign BRAM_Addr = {Req_Addr[32-C_PORT_AWIDTH:29], 2'b00};
    assign BRAM_Dout = Req_WData;
    assign Req_Ready = ready_q;

    assign unused_addr_lsbs = ^Req_Addr[30:31];

    assign push      = pipe_vld_q[C_READ_LATENCY-1];
    assign push_err  = pipe_err_q[C_READ_LATENCY-1];
    assign push_data = push_err ? 32'h0 : BRAM_Din;

    assign Rsp_Valid = (count_q != '0);
    assign pop       = Rsp_Valid & Rsp_Ready;
    assign Rsp_RData = Rsp_Valid ? data_mem[rd_ptr_q] : 32'h0;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pipe_vld_d    = '0;
        pipe_err_d    = '0;
        pipe_vld_d[0] = rd_issue;
        pipe_err_d[0] = rd_issue & req_oob;
        for (int i = 1; i < int'(C_READ_LATENCY); i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_err_d[i] = pipe_err_q[i-1];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pipe_cnt = '0;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        for (int i = 0; i < int'(C_READ_LATENCY); i++) begin
            pipe_cnt = pipe_cnt + CW'(pipe_vld_d[i]);
        end
        // Every read in the pipe owns a FIFO slot, so the FIFO cannot overflow.
        ready_d = (pipe_cnt + count_d) < CW'(D);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            pipe_vld_q <= '0;
            pipe_err_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            pipe_err_q <= pipe_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
        end
    end

    // NOTE: FIFO storage is not reset; outputs are gated by Rsp_Valid, so stale entries are never seen.
    always_ff @(posedge Clk) begin
        if (push) data_mem[wr_ptr_q] <= push_data;
    end

`ifdef BRAM_PORT_MASTER_RANGE_CHECK_EN
    logic err_mem [D];

    assign req_oob = (Req_Addr >= 32'(C_MEMSIZE));
    assign Rsp_Err = Rsp_Valid & err_mem[rd_ptr_q];

    always_ff @(posedge Clk) begin
        if (push) err_mem[wr_ptr_q] <= push_err;
    end
`else
    assign req_oob = 1'b0;
    assign Rsp_Err = 1'b0;
`endif

endmodule

// File: tb/tb_bram_port_master.sv
// Randomized bench for bram_port_master: BRAM model on the port side, and a queue-based
// reference of accepted requests, memory contents and credits on the stream side.
`timescale 1ns/1ps
module tb_bram_port_master;

    localparam int L       = 1;
    localparam int D       = L + 2;
    localparam int MEMSIZE = 'h8000;
    localparam int WORDS   = MEMSIZE / 4;
`ifdef BRAM_PORT_MASTER_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Req_Valid = 1'b0;
    logic        Req_Ready;
    logic        Req_Wr = 1'b0;
    logic [0:31] Req_Addr = '0;
    logic [0:3]  Req_BE = '0;
    logic [0:31] Req_WData = '0;
    logic        Rsp_Valid;
    logic        Rsp_Ready = 1'b1;
    logic [0:31] Rsp_RData;
    logic        Rsp_Err;
    logic        BRAM_Rst;
    logic        BRAM_Clk;
    logic        BRAM_EN;
    logic [0:3]  BRAM_WEN;
    logic [0:31] BRAM_Addr;
    logic [0:31] BRAM_Dout;
    logic [0:31] BRAM_Din;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int stall_cnt = 0;
    bit rand_rsp = 1'b0;
    bit rdy_exp = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          avail;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] ref_mem  [WORDS];
    logic [31:0] bram_mem [WORDS];
    logic [31:0] din_stage [L];

    always #5 Clk = ~Clk;

    bram_port_master #(
        .C_MEMSIZE      (MEMSIZE),
        .C_READ_LATENCY (L),
        .C_PORT_AWIDTH  (32)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Req_Valid (Req_Valid),
        .Req_Ready (Req_Ready),
        .Req_Wr    (Req_Wr),
        .Req_Addr  (Req_Addr),
        .Req_BE    (Req_BE),
        .Req_WData (Req_WData),
        .Rsp_Valid (Rsp_Valid),
        .Rsp_Ready (Rsp_Ready),
        .Rsp_RData (Rsp_RData),
        .Rsp_Err   (Rsp_Err),
        .BRAM_Rst  (BRAM_Rst),
        .BRAM_Clk  (BRAM_Clk),
        .BRAM_EN   (BRAM_EN),
        .BRAM_WEN  (BRAM_WEN),
        .BRAM_Addr (BRAM_Addr),
        .BRAM_Dout (BRAM_Dout),
        .BRAM_Din  (BRAM_Din)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Read-first BRAM with L clock edges from EN-sampled to Din valid.
    always @(posedge BRAM_Clk) begin : bram_model
        int          idx;
        logic [31:0] d;
        for (int i = L - 1; i > 0; i--) din_stage[i] <= din_stage[i-1];
        if (BRAM_EN) begin
            idx = int'((BRAM_Addr >> 2) & (WORDS - 1));
            din_stage[0] <= bram_mem[idx];
            d = BRAM_Dout;
            for (int b = 0; b < 4; b++) begin
                if (BRAM_WEN[b]) bram_mem[idx][31-8*b -: 8] = d[31-8*b -: 8];
            end
        end
    end
    assign BRAM_Din = din_stage[L-1];

    // Reference: every accepted read becomes an in-order response visible L+1 cycles later;
    // the port accepts while fewer than D reads are outstanding.
    always @(negedge Clk) begin : monitor
        logic        fire;
        logic        oob;
        logic        exp_valid;
        logic [31:0] mask;
        logic [31:0] addr;
        int          idx;
        rsp_t        r;
        check("bram_rst", BRAM_Rst, !Rst_n);
        if (!Rst_n) begin
            exp_q.delete();
            rdy_exp = 1'b0;
        end else begin
            addr      = Req_Addr;
            fire      = Req_Valid & Req_Ready;
            oob       = RANGE_CHK && (addr >= MEMSIZE);
            idx       = int'((addr >> 2) % WORDS);
            exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
            check("req_ready", Req_Ready, rdy_exp);
            check("bram_en", BRAM_EN, fire & !oob);
            check("bram_wen", BRAM_WEN, (fire && Req_Wr && !oob) ? Req_BE : 4'b0);
            if (fire) check("bram_addr", BRAM_Addr, addr & ~32'h3);
            if (fire && Req_Wr) check("bram_dout", BRAM_Dout, Req_WData);
            check("rsp_valid", Rsp_Valid, exp_valid);
            if (exp_valid) check("rsp_rdata", Rsp_RData, exp_q[0].data);
            check("rsp_err", Rsp_Err, exp_valid ? exp_q[0].err : 1'b0);

            if (Rsp_Valid && Rsp_Ready && exp_valid) void'(exp_q.pop_front());
            if (fire && Req_Wr && !oob) begin
                mask = '0;
                for (int b = 0; b < 4; b++) if (Req_BE[b]) mask |= 32'hFF00_0000 >> (8 * b);
                ref_mem[idx] = (ref_mem[idx] & ~mask) | (Req_WData & mask);
            end
            if (fire && !Req_Wr) begin
                r.data  = oob ? 32'h0 : ref_mem[idx];
                r.err   = oob;
                r.avail = cyc + L + 1;
                exp_q.push_back(r);
            end
            rdy_exp = (exp_q.size() < D);
        end
        cyc++;
    end

    task automatic step();
        @(posedge Clk);
        #1;
        if (rand_rsp) Rsp_Ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        Req_Valid = 1'b0;
        repeat (n) step();
    endtask

    // Presents one request and holds it until accepted; returns just after the accepting edge.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
        bit acc = 1'b0;
        int n = 0;
        Req_Valid = 1'b1;
        Req_Wr    = wr;
        Req_Addr  = addr;
        Req_BE    = be;
        Req_WData = wdata;
        while (!acc && n < 64) begin
            @(negedge Clk);
            acc = Req_Ready;
            step();
            if (!acc) stall_cnt++;
            n++;
        end
        check("issue_accept", acc, 1'b1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int          acc_cnt;
        bit          a;
        int          n;
        logic [31:0] addr;

        for (int i = 0; i < WORDS; i++) begin
            ref_mem[i]  = '0;
            bram_mem[i] = '0;
        end
        for (int i = 0; i < L; i++) din_stage[i] = '0;

        // Reset state.
        repeat (3) @(posedge Clk);
        #1;
        check("rst_req_ready", Req_Ready, 1'b0);
        check("rst_rsp_valid", Rsp_Valid, 1'b0);
        check("rst_rsp_rdata", Rsp_RData, 32'h0);
        check("rst_rsp_err", Rsp_Err, 1'b0);
        check("rst_bram_rst", BRAM_Rst, 1'b1);
        Rst_n = 1'b1;
        check("rel_req_ready", Req_Ready, 1'b0);
        step();
        check("first_clk_ready", Req_Ready, 1'b1);

        // Full-word write then read back; data two cycles after acceptance.
        issue(1'b1, 32'h10, 4'b1111, 32'h1122_3344);
        issue(1'b0, 32'h10, 4'b0000, 32'h0);
        Req_Valid = 1'b0;
        check("lat_not_yet", Rsp_Valid, 1'b0);
        step();
        check("lat_valid", Rsp_Valid, 1'b1);
        check("lat_data", Rsp_RData, 32'h1122_3344);
        idle(3);

        // Partial byte-enable write over zero.
        issue(1'b1, 32'h20, 4'b1010, 32'hAABB_CCDD);
        issue(1'b0, 32'h20, 4'b0000, 32'h0);
        Req_Valid = 1'b0;
        step();
        check("be_data", Rsp_RData, 32'hAA00_CC00);
        idle(3);

        // Back-to-back reads with the consumer always ready.
        stall_cnt = 0;
        for (int i = 0; i < 16; i++) issue(1'b0, 32'(i * 4), 4'b0000, 32'h0);
        Req_Valid = 1'b0;
        check("b2b_stalls", stall_cnt, 0);
        idle(5);

        // Consumer stalled: exactly D reads accepted, then acceptance resumes after draining.
        Rsp_Ready = 1'b0;
        Req_Valid = 1'b1;
        Req_Wr    = 1'b0;
        Req_Addr  = 32'h0;
        acc_cnt   = 0;
        repeat (8) begin
            @(negedge Clk);
            a = Req_Ready;
            step();
            if (a) begin
                acc_cnt++;
                Req_Addr = Req_Addr + 32'd4;
            end
        end
        check("credit_accepts", acc_cnt, D);
        Rsp_Ready = 1'b1;
        issue(1'b0, Req_Addr, 4'b0000, 32'h0);
        idle(6);

        // Reset with reads in flight discards them.
        Rsp_Ready = 1'b0;
        issue(1'b0, 32'h10, 4'b0000, 32'h0);
        issue(1'b0, 32'h20, 4'b0000, 32'h0);
        idle(1);
        check("pre_rst_valid", Rsp_Valid, 1'b1);
        Rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", Rsp_Valid, 1'b0);
        check("midrst_req_ready", Req_Ready, 1'b0);
        check("midrst_rsp_rdata", Rsp_RData, 32'h0);
        repeat (2) @(posedge Clk);
        #1;
        Rst_n     = 1'b1;
        Rsp_Ready = 1'b1;
        idle(8);

        // Address at C_MEMSIZE: checked build answers 0 with error, plain build reads word 0 (still zero).
        issue(1'b0, 32'h8000, 4'b0000, 32'h0);
        Req_Valid = 1'b0;
        step();
        check("oob_valid", Rsp_Valid, 1'b1);
        check("oob_rdata", Rsp_RData, 32'h0);
        check("oob_err", Rsp_Err, RANGE_CHK);
        idle(3);

        // Random traffic with a randomly stalling consumer.
        rand_rsp = 1'b1;
        repeat (400) begin
            if ($urandom_range(0, 9) < 7) begin
                addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) addr = addr | 32'h8000;
                issue(1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)), $urandom);
            end else begin
                idle(1);
            end
        end

        rand_rsp  = 1'b0;
        Req_Valid = 1'b0;
        Rsp_Ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            step();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
